pipe_hazard_unit: RTL and testbench

Parametrised hazard and forwarding controller for the in-order RV32 pipeline. It sits beside the decode/execute boundary and keeps a shadow pipeline of destination-register tags for every stage after decode. From that shadow pipeline it drives decode stall, execute bubble and fetch/decode flush, plus per-operand forwarding selects. This replaces the fixed, hazard-blind stage chaining and supports configurable depth, load latency and forwarding on/off.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_hazard_unit.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package pipe_pkg;

    // Widest register address the shadow entry can hold; narrower ports are zero-extended.
    localparam int unsigned MAX_REG_ADDR_W = 8;
    localparam int unsigned FWD_REGFILE    = 0;

    typedef struct packed {
        logic                      valid;
        logic [MAX_REG_ADDR_W-1:0] rd;
        logic                      wen;
        logic                      is_load;
    } shadow_entry_t;

    function automatic int unsigned sel_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles, holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: shadow pipeline of destination tags drives
// decode stall, execute bubble, front-end flush and per-operand forwarding selects.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned STAGES     = 3,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           de_valid,
    input  logic [REG_ADDR_W-1:0]          de_rs1,
    input  logic [REG_ADDR_W-1:0]          de_rs2,
    input  logic                           de_rs1_used,
    input  logic                           de_rs2_used,
    input  logic [REG_ADDR_W-1:0]          de_rd,
    input  logic                           de_reg_wen,
    input  logic                           de_is_load,
    input  logic                           redirect,
    output logic                           stall_de,
    output logic                           bubble_exe,
    output logic                           flush,
    output logic [sel_width(STAGES)-1:0]   fwd_a_sel,
    output logic [sel_width(STAGES)-1:0]   fwd_b_sel,
    output logic [STAGES-1:0]              stage_valid,
    output logic [CNT_W-1:0]               stall_cnt,
    output logic [CNT_W-1:0]               flush_cnt
);

    localparam int unsigned SEL_W = sel_width(STAGES);

    shadow_entry_t     shadow [STAGES];
    logic [STAGES-1:0] match_a;
    logic [STAGES-1:0] match_b;
    logic [STAGES-1:0] load_vec;
    logic              haz_a;
    logic              haz_b;

    // Youngest (lowest index) match decides; returns {hazard, select}.
    function automatic logic [SEL_W:0] resolve(input logic [STAGES-1:0] m,
                                               input logic [STAGES-1:0] ld);
        logic             found;
        logic             hz;
        logic [SEL_W-1:0] sel;
        found = 1'b0;
        hz    = 1'b0;
        sel   = SEL_W'(FWD_REGFILE);
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (!found && m[k]) begin
                found = 1'b1;
                if (FWD_EN == 0) begin
                    hz = 1'b1;
                end else if (ld[k] && (k < LOAD_READY)) begin
                    hz = 1'b1;
                end else begin
                    sel = SEL_W'(k + 1);
                end
            end
        end
        return {hz, sel};
    endfunction

    always_comb begin
        match_a  = '0;
        match_b  = '0;
        load_vec = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            load_vec[k]    = shadow[k].is_load;
            stage_valid[k] = shadow[k].valid;
            match_a[k] = de_valid && de_rs1_used && shadow[k].valid && shadow[k].wen &&
                         (shadow[k].rd != '0) && (shadow[k].rd == MAX_REG_ADDR_W'(de_rs1));
            match_b[k] = de_valid && de_rs2_used && shadow[k].valid && shadow[k].wen &&
                         (shadow[k].rd != '0) && (shadow[k].rd == MAX_REG_ADDR_W'(de_rs2));
        end
    end

    assign {haz_a, fwd_a_sel} = resolve(match_a, load_vec);
    assign {haz_b, fwd_b_sel} = resolve(match_b, load_vec);

    // Shadow state is cleared under reset, so only the redirect-driven outputs need gating.
    always_comb begin
        stall_de   = (haz_a || haz_b) && !redirect;
        flush      = redirect && rst;
        bubble_exe = stall_de || flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            if (de_valid && !bubble_exe) begin
                shadow[0] <= '{valid:   1'b1,
                               rd:      MAX_REG_ADDR_W'(de_rd),
                               wen:     de_reg_wen,
                               is_load: de_is_load};
            end else begin
                shadow[0] <= '0;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                shadow[k] <= shadow[k-1];
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (stall_de),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: vector table, hand sequences and random stimulus against a tag-list model.
module tb_pipe_hazard_unit;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       de_valid, de_rs1_used, de_rs2_used, de_reg_wen, de_is_load, redirect;
    logic [4:0] de_rs1, de_rs2, de_rd;

    logic        d_st, d_bu, d_fl, n_st, n_bu, n_fl, q_st, q_bu, q_fl;
    logic [1:0]  d_sa, d_sb, n_sa, n_sb, q_sa, q_sb;
    logic [2:0]  d_sv, n_sv, q_sv;
    logic [15:0] d_sc, d_fc, n_sc, n_fc;
    logic [3:0]  q_sc, q_fc;

    pipe_hazard_unit u_dut (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
        .de_reg_wen(de_reg_wen), .de_is_load(de_is_load), .redirect(redirect),
        .stall_de(d_st), .bubble_exe(d_bu), .flush(d_fl), .fwd_a_sel(d_sa), .fwd_b_sel(d_sb),
        .stage_valid(d_sv), .stall_cnt(d_sc), .flush_cnt(d_fc));

    pipe_hazard_unit #(.FWD_EN(0)) u_nof (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
        .de_reg_wen(de_reg_wen), .de_is_load(de_is_load), .redirect(redirect),
        .stall_de(n_st), .bubble_exe(n_bu), .flush(n_fl), .fwd_a_sel(n_sa), .fwd_b_sel(n_sb),
        .stage_valid(n_sv), .stall_cnt(n_sc), .flush_cnt(n_fc));

    pipe_hazard_unit #(.FWD_EN(0), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
        .de_reg_wen(de_reg_wen), .de_is_load(de_is_load), .redirect(redirect),
        .stall_de(q_st), .bubble_exe(q_bu), .flush(q_fl), .fwd_a_sel(q_sa), .fwd_b_sel(q_sb),
        .stage_valid(q_sv), .stall_cnt(q_sc), .flush_cnt(q_fc));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: per configuration (0 = forwarding, 1 = no forwarding) a list of in-flight
    // tags indexed by age; element k is the instruction k cycles past decode.
    logic        mv [2][3];
    logic [4:0]  mrd[2][3];
    logic        mw [2][3];
    logic        ml [2][3];
    int unsigned sc[3], fc[3];
    int unsigned cmax[3] = '{65535, 65535, 15};

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 3; k++) begin
                mv[c][k] = 1'b0; mrd[c][k] = '0; mw[c][k] = 1'b0; ml[c][k] = 1'b0;
            end
        for (int i = 0; i < 3; i++) begin sc[i] = 0; fc[i] = 0; end
    endtask

    function automatic void find(input int c, input logic [4:0] rs, input logic used,
                                 output logic hz, output logic [1:0] sel);
        logic found;
        found = 1'b0; hz = 1'b0; sel = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && de_valid && used && mv[c][k] && mw[c][k] &&
                mrd[c][k] != 5'd0 && mrd[c][k] == rs) begin
                found = 1'b1;
                if (c == 1) hz = 1'b1;
                else if (ml[c][k] && k < 2) hz = 1'b1;
                else sel = 2'(k + 1);
            end
        end
    endfunction

    function automatic void eval(input int c, output logic st, output logic bu, output logic fl,
                                 output logic [1:0] sa, output logic [1:0] sb);
        logic ha, hb;
        find(c, de_rs1, de_rs1_used, ha, sa);
        find(c, de_rs2, de_rs2_used, hb, sb);
        st = (ha | hb) & ~redirect & rst;
        fl = redirect & rst;
        bu = st | fl;
    endfunction

    task automatic model_update();
        logic st[2], bu[2], fl[2];
        logic [1:0] sa, sb;
        int cf;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) eval(c, st[c], bu[c], fl[c], sa, sb);
        for (int c = 0; c < 2; c++) begin
            for (int k = 2; k >= 1; k--) begin
                mv[c][k] = mv[c][k-1]; mrd[c][k] = mrd[c][k-1];
                mw[c][k] = mw[c][k-1]; ml[c][k] = ml[c][k-1];
            end
            mv[c][0] = de_valid & ~bu[c]; mrd[c][0] = de_rd;
            mw[c][0] = de_reg_wen;        ml[c][0] = de_is_load;
        end
        for (int i = 0; i < 3; i++) begin
            cf = (i == 0) ? 0 : 1;
            if (st[cf] && sc[i] < cmax[i]) sc[i]++;
            if (fl[cf] && fc[i] < cmax[i]) fc[i]++;
        end
    endtask

    task automatic chk_dut(input string tag, input int i, input logic st, input logic bu,
                           input logic fl, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [2:0] sv, input logic [31:0] scv, input logic [31:0] fcv);
        logic est, ebu, efl;
        logic [1:0] esa, esb;
        int cf;
        cf = (i == 0) ? 0 : 1;
        eval(cf, est, ebu, efl, esa, esb);
        chk({tag, "_stall_de"},    32'(st), 32'(est));
        chk({tag, "_bubble_exe"},  32'(bu), 32'(ebu));
        chk({tag, "_flush"},       32'(fl), 32'(efl));
        chk({tag, "_fwd_a_sel"},   32'(sa), 32'(esa));
        chk({tag, "_fwd_b_sel"},   32'(sb), 32'(esb));
        chk({tag, "_stage_valid"}, 32'(sv), 32'({mv[cf][2], mv[cf][1], mv[cf][0]}));
        chk({tag, "_stall_cnt"},   scv, sc[i]);
        chk({tag, "_flush_cnt"},   fcv, fc[i]);
    endtask

    task automatic check_model();
        chk_dut("dflt", 0, d_st, d_bu, d_fl, d_sa, d_sb, d_sv, 32'(d_sc), 32'(d_fc));
        chk_dut("nofwd", 1, n_st, n_bu, n_fl, n_sa, n_sb, n_sv, 32'(n_sc), 32'(n_fc));
        chk_dut("cnt4", 2, q_st, q_bu, q_fl, q_sa, q_sb, q_sv, 32'(q_sc), 32'(q_fc));
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       w, l, rdr;
        logic       est, ebu, efl;
        logic [1:0] esa, esb;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic w, input logic l, input logic rdr,
                                input logic est, input logic ebu, input logic efl,
                                input logic [1:0] esa, input logic [1:0] esb);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
        r.w = w; r.l = l; r.rdr = rdr;
        r.est = est; r.ebu = ebu; r.efl = efl; r.esa = esa; r.esb = esb;
        return r;
    endfunction

    task automatic apply(input vec_t r);
        de_valid = r.v; de_rs1 = r.rs1; de_rs2 = r.rs2; de_rs1_used = r.u1; de_rs2_used = r.u2;
        de_rd = r.rd; de_reg_wen = r.w; de_is_load = r.l; redirect = r.rdr;
    endtask

    vec_t tbl[15];
    vec_t idle, prod3, read3;
    int   cyc;
    logic stall_now;

    initial begin
        idle  = mk(F, 5'd0, 5'd0, F, F, 5'd0, F, F, F, F, F, F, 2'd0, 2'd0);
        prod3 = mk(T, 5'd0, 5'd0, F, F, 5'd3, T, F, F, F, F, F, 2'd0, 2'd0);
        read3 = mk(T, 5'd3, 5'd0, T, F, 5'd0, F, F, F, F, F, F, 2'd0, 2'd0);

        //            v  rs1    rs2    u1 u2 rd     w  l  rdr  st bu fl sa    sb
        tbl[0]  = mk(T, 5'd1, 5'd2, F, F, 5'd5, T, F, F,   F, F, F, 2'd0, 2'd0);
        tbl[1]  = mk(T, 5'd5, 5'd2, T, F, 5'd6, T, F, F,   F, F, F, 2'd1, 2'd0);
        tbl[2]  = mk(T, 5'd5, 5'd0, T, F, 5'd0, F, F, F,   F, F, F, 2'd2, 2'd0);
        tbl[3]  = mk(T, 5'd5, 5'd0, T, F, 5'd0, F, F, F,   F, F, F, 2'd3, 2'd0);
        tbl[4]  = idle;
        tbl[5]  = mk(T, 5'd0, 5'd0, F, F, 5'd7, T, T, F,   F, F, F, 2'd0, 2'd0);
        tbl[6]  = mk(T, 5'd0, 5'd7, F, T, 5'd8, T, F, F,   T, T, F, 2'd0, 2'd0);
        tbl[7]  = mk(T, 5'd0, 5'd7, F, T, 5'd8, T, F, F,   T, T, F, 2'd0, 2'd0);
        tbl[8]  = mk(T, 5'd0, 5'd7, F, T, 5'd8, T, F, F,   F, F, F, 2'd0, 2'd3);
        tbl[9]  = idle;
        tbl[10] = mk(T, 5'd0, 5'd0, F, F, 5'd0, T, F, F,   F, F, F, 2'd0, 2'd0);
        tbl[11] = mk(T, 5'd0, 5'd0, T, T, 5'd0, F, F, F,   F, F, F, 2'd0, 2'd0);
        tbl[12] = mk(T, 5'd0, 5'd0, F, F, 5'd9, T, T, F,   F, F, F, 2'd0, 2'd0);
        tbl[13] = mk(T, 5'd9, 5'd0, T, F, 5'd0, F, F, T,   F, T, T, 2'd0, 2'd0);
        tbl[14] = idle;

        // Reset, including a redirect while held: every output must read 0.
        rst = 1'b0;
        apply(idle);
        redirect = 1'b1;
        model_reset();
        sample();
        chk("reset_flush", 32'(d_fl), 32'd0);
        redirect = 1'b0;
        advance();
        sample();
        advance();
        rst = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            sample();
            chk($sformatf("tbl%0d_stall_de", i),   32'(d_st), 32'(tbl[i].est));
            chk($sformatf("tbl%0d_bubble_exe", i), 32'(d_bu), 32'(tbl[i].ebu));
            chk($sformatf("tbl%0d_flush", i),      32'(d_fl), 32'(tbl[i].efl));
            chk($sformatf("tbl%0d_fwd_a_sel", i),  32'(d_sa), 32'(tbl[i].esa));
            chk($sformatf("tbl%0d_fwd_b_sel", i),  32'(d_sb), 32'(tbl[i].esb));
            if (i == 14) begin
                chk("redirect_stage_valid", 32'(d_sv), 32'd6);
                chk("load_use_stall_cnt",   32'(d_sc), 32'd2);
                chk("redirect_flush_cnt",   32'(d_fc), 32'd1);
            end
            advance();
        end

        // No forwarding: reader of x3 waits until the producer retires.
        for (int i = 0; i < 3; i++) begin apply(idle); sample(); advance(); end
        apply(prod3); sample(); advance();
        apply(read3);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk($sformatf("nofwd_stall_c%0d", i), 32'(n_st), (i < 3) ? 32'd1 : 32'd0);
            chk($sformatf("nofwd_sel_c%0d", i),   32'(n_sa), 32'd0);
            chk($sformatf("fwd_sel_c%0d", i),     32'(d_sa), (i < 3) ? 32'(i + 1) : 32'd0);
            advance();
        end
        apply(idle); sample(); advance();

        // Drive enough stalls into the 4-bit counter instance to saturate it.
        for (int r = 0; r < 7; r++) begin
            apply(prod3); sample(); advance();
            apply(read3);
            cyc = 0;
            do begin
                sample();
                stall_now = q_st;
                advance();
                cyc++;
            end while (stall_now && cyc < 8);
            chk($sformatf("round%0d_cycles", r), 32'(cyc), 32'd4);
        end
        chk("cnt4_saturated", 32'(q_sc), 32'd15);

        // Asynchronous reset in the middle of a stall.
        apply(prod3); sample(); advance();
        apply(read3);
        sample();
        chk("pre_reset_stall", 32'(n_st), 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_stall_de",    32'(n_st), 32'd0);
        chk("rst_cnt4_stall",  32'(q_sc), 32'd0);
        chk("rst_cnt4_flush",  32'(q_fc), 32'd0);
        chk("rst_stage_valid", 32'({d_sv, n_sv, q_sv}), 32'd0);
        chk("rst_dflt_stall",  32'(d_sc), 32'd0);
        check_model();
        advance(); sample(); advance();
        rst = 1'b1;

        for (int i = 0; i < 400; i++) begin
            de_valid    = ($urandom_range(0, 9) < 8);
            de_rs1      = 5'($urandom_range(0, 7));
            de_rs2      = 5'($urandom_range(0, 7));
            de_rs1_used = 1'($urandom_range(0, 1));
            de_rs2_used = 1'($urandom_range(0, 1));
            de_rd       = 5'($urandom_range(0, 7));
            de_reg_wen  = ($urandom_range(0, 3) != 0);
            de_is_load  = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
